pipe_run_monitor: RTL and testbench

//  Synthesizable run controller and PC monitor for the pipelined MIPS datapath.

---
 rtl/pipe_mon_pkg.sv | 17 +
 rtl/pipe_mon_trace_buf.sv | 44 ++++
 rtl/pipe_run_monitor.sv | 100 ++++++++++
 tb/tb_pipe_run_monitor.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mon_pkg.sv
// pipe_mon_pkg: shared types and defaults for the pipelined-datapath run monitor.
//   state_t     : sequencer states IDLE -> RESET -> RUN -> DONE
//   CNT_W       : width of the cycle, reset and stall counters
//   DEF_*       : default parameter values used by pipe_run_monitor
//   sat_inc     : saturating increment for CNT_W-wide counters
package pipe_mon_pkg;
  typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;
  localparam int CNT_W           = 32;
  localparam int DEF_PC_W        = 32;
  localparam int DEF_RST_CYCLES  = 1;
  localparam int DEF_RUN_CYCLES  = 10;
  localparam int DEF_STALL_LIMIT = 4;
  localparam int DEF_TRACE_DEPTH = 16;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/pipe_mon_trace_buf.sv
// pipe_mon_trace_buf: circular PC trace, oldest entry overwritten once full.
//   i_clk, i_rst (sync, active-low) : clock and reset of pointer/count
//   i_clr                           : clear pointer and count (new run)
//   i_we, i_pc                      : write one PC at the write pointer
//   i_rd_idx                        : read index, 0 = oldest valid entry
//   o_rd_pc                         : combinational read data, 0 past the valid range
//   o_count                         : valid entries, saturates at DEPTH
module pipe_mon_trace_buf
  import pipe_mon_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int DEPTH = DEF_TRACE_DEPTH
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clr,
  input  logic                       i_we,
  input  logic [PC_W-1:0]            i_pc,
  input  logic [$clog2(DEPTH)-1:0]   i_rd_idx,
  output logic [PC_W-1:0]            o_rd_pc,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [PC_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW:0]     r_count;
  logic [AW-1:0]   w_rd_addr;
  // Storage carries no reset so it can map onto RAM; reads are masked by r_count.
  always_ff @(posedge i_clk)
    if (i_we) r_mem[r_wr_ptr] <= i_pc;
  always_ff @(posedge i_clk) begin
    if (!i_rst || i_clr) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_we) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      r_count  <= (r_count == (AW+1)'(DEPTH)) ? r_count : r_count + 1'b1;
    end
  end
  // Oldest entry sits count slots behind the write pointer; a full buffer wraps to the pointer itself.
  assign w_rd_addr = r_wr_ptr - r_count[AW-1:0] + i_rd_idx;
  assign o_rd_pc   = ({1'b0, i_rd_idx} < r_count) ? r_mem[w_rd_addr] : '0;
  assign o_count   = r_count;
endmodule

// File: rtl/pipe_run_monitor.sv
// pipe_run_monitor: reset/run sequencer and PC monitor for the pipelined datapath.
//   i_clk, i_rst (sync, active-low)        : clock and reset
//   i_start                                : pulse, begins reset+run from IDLE or DONE
//   i_pc_in                                : datapath PC, sampled every RUN cycle
//   o_core_rst                             : active-high datapath reset (IDLE, RESET)
//   o_running / o_done                     : in RUN / in DONE
//   o_halted / o_timeout                   : sticky PC-stall halt / cycle budget exhausted
//   o_cycle_cnt                            : RUN cycles elapsed, saturating
//   i_trace_rd_idx, o_trace_rd_pc          : trace read port, index 0 = oldest
//   o_trace_count                          : valid trace entries
// Macro PIPE_MON_TRACE_EN builds the trace buffer; without it the trace outputs read 0.
module pipe_run_monitor
  import pipe_mon_pkg::*;
#(
  parameter int PC_W        = DEF_PC_W,
  parameter int RST_CYCLES  = DEF_RST_CYCLES,
  parameter int RUN_CYCLES  = DEF_RUN_CYCLES,
  parameter int STALL_LIMIT = DEF_STALL_LIMIT,
  parameter int TRACE_DEPTH = DEF_TRACE_DEPTH
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_start,
  input  logic [PC_W-1:0]                  i_pc_in,
  output logic                             o_core_rst,
  output logic                             o_running,
  output logic                             o_done,
  output logic                             o_halted,
  output logic                             o_timeout,
  output logic [CNT_W-1:0]                 o_cycle_cnt,
  input  logic [$clog2(TRACE_DEPTH)-1:0]   i_trace_rd_idx,
  output logic [PC_W-1:0]                  o_trace_rd_pc,
  output logic [$clog2(TRACE_DEPTH):0]     o_trace_count
);
  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_rst_cnt, r_cycle_cnt, r_stall_cnt, w_stall_nx;
  logic [PC_W-1:0]  r_prev_pc;
  logic             r_halted, r_timeout;
  logic             w_run, w_start_seq, w_halt_hit, w_to_hit;
  always_comb begin
    w_run       = r_state == RUN;
    w_start_seq = i_start && (r_state == IDLE || r_state == DONE);
    // A zero cycle count marks the first RUN cycle, which has no previous PC to compare.
    w_stall_nx  = (r_cycle_cnt != '0 && i_pc_in == r_prev_pc) ? r_stall_cnt + 1'b1 : '0;
    w_halt_hit  = w_run && w_stall_nx == CNT_W'(STALL_LIMIT - 1);
    w_to_hit    = w_run && (RUN_CYCLES != 0) && r_cycle_cnt == CNT_W'(RUN_CYCLES - 1);
    w_state_nx  = w_start_seq                                 ? RESET :
                  (r_state == RESET && r_rst_cnt == CNT_W'(1)) ? RUN   :
                  (w_halt_hit || w_to_hit)                     ? DONE  : r_state;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst || w_start_seq) begin
      r_rst_cnt   <= i_rst ? CNT_W'(RST_CYCLES) : '0;
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
      r_prev_pc   <= '0;
      r_halted    <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      if (r_state == RESET) r_rst_cnt <= r_rst_cnt - 1'b1;
      if (w_run) begin
        r_cycle_cnt <= sat_inc(r_cycle_cnt);
        r_stall_cnt <= w_stall_nx;
        r_prev_pc   <= i_pc_in;
        r_halted    <= r_halted | w_halt_hit;
        r_timeout   <= r_timeout | w_to_hit;
      end
    end
  end
  assign o_core_rst  = r_state == IDLE || r_state == RESET;
  assign o_running   = w_run;
  assign o_done      = r_state == DONE;
  assign o_halted    = r_halted;
  assign o_timeout   = r_timeout;
  assign o_cycle_cnt = r_cycle_cnt;
`ifdef PIPE_MON_TRACE_EN
  pipe_mon_trace_buf #(
    .PC_W (PC_W),
    .DEPTH(TRACE_DEPTH)
  ) u_trace (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_start_seq),
    .i_we    (w_run),
    .i_pc    (i_pc_in),
    .i_rd_idx(i_trace_rd_idx),
    .o_rd_pc (o_trace_rd_pc),
    .o_count (o_trace_count)
  );
`else
  logic w_unused_idx;
  assign w_unused_idx  = ^i_trace_rd_idx;
  assign o_trace_rd_pc = '0;
  assign o_trace_count = '0;
`endif
endmodule

// File: tb/tb_pipe_run_monitor.sv
// tb_pipe_run_monitor: directed checks of sequencing, timeout, halt, trace and abort/restart.
module tb_pipe_run_monitor;
`ifdef PIPE_MON_TRACE_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [31:0] pc_a = '0, pc_b = '0;
  logic [3:0]  idx_a = '0, idx_b = '0;
  logic        crst_a, run_a, done_a, halt_a, to_a;
  logic        crst_b, run_b, done_b, halt_b, to_b;
  logic [31:0] cnt_a, cnt_b, tpc_a, tpc_b;
  logic [4:0]  tcnt_a, tcnt_b;
  int          checks = 0, fails = 0;
  always #5 clk = ~clk;
  pipe_run_monitor #(.RUN_CYCLES(10)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_pc_in(pc_a),
    .o_core_rst(crst_a), .o_running(run_a), .o_done(done_a), .o_halted(halt_a),
    .o_timeout(to_a), .o_cycle_cnt(cnt_a), .i_trace_rd_idx(idx_a),
    .o_trace_rd_pc(tpc_a), .o_trace_count(tcnt_a)
  );
  pipe_run_monitor #(.RUN_CYCLES(20)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_pc_in(pc_b),
    .o_core_rst(crst_b), .o_running(run_b), .o_done(done_b), .o_halted(halt_b),
    .o_timeout(to_b), .o_cycle_cnt(cnt_b), .i_trace_rd_idx(idx_b),
    .o_trace_rd_pc(tpc_b), .o_trace_count(tcnt_b)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // status vector: {core_rst, running, done, halted, timeout}
  task automatic test_reset;
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({crst_a, run_a, done_a, halt_a, to_a} !== 5'b10000) begin
      $display("FAIL reset_status got %b want 10000", {crst_a, run_a, done_a, halt_a, to_a});
      fails++;
    end
    checks++;
    if (cnt_a !== 32'd0 || tcnt_a !== 5'd0) begin
      $display("FAIL reset_counts got cnt=%0d tcnt=%0d want 0/0", cnt_a, tcnt_a);
      fails++;
    end
    rst = 1'b1;
    tick();
  endtask
  task automatic test_timeout;
    int runs;
    runs = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++;
    if ({crst_a, run_a, done_a} !== 3'b100) begin
      $display("FAIL t1_reset_phase got %b want 100", {crst_a, run_a, done_a});
      fails++;
    end
    tick();
    checks++;
    if ({crst_a, run_a, done_a} !== 3'b010 || cnt_a !== 32'd0) begin
      $display("FAIL t1_run_entry got %b cnt=%0d want 010 cnt=0", {crst_a, run_a, done_a}, cnt_a);
      fails++;
    end
    for (int k = 0; k < 12; k++) begin
      pc_a = 32'(4 * k);
      if (run_a) runs++;
      tick();
    end
    checks++;
    if (runs !== 10) begin
      $display("FAIL t1_run_len got %0d want 10", runs);
      fails++;
    end
    checks++;
    if ({crst_a, run_a, done_a, halt_a, to_a} !== 5'b00101 || cnt_a !== 32'd10) begin
      $display("FAIL t1_done got %b cnt=%0d want 00101 cnt=10", {crst_a, run_a, done_a, halt_a, to_a}, cnt_a);
      fails++;
    end
    idx_a = 4'd9;
    #1;
    checks++;
    if (tcnt_a !== (TR ? 5'd10 : 5'd0) || tpc_a !== (TR ? 32'h24 : 32'h0)) begin
      $display("FAIL t1_trace got tcnt=%0d pc=%h want %0d/%h", tcnt_a, tpc_a, TR ? 10 : 0, TR ? 32'h24 : 32'h0);
      fails++;
    end
    idx_a = 4'd10;
    #1;
    checks++;
    if (tpc_a !== 32'h0) begin
      $display("FAIL t1_trace_oob got %h want 0", tpc_a);
      fails++;
    end
  endtask
  task automatic test_halt;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    for (int k = 1; k <= 6; k++) begin
      pc_a = (k < 3) ? 32'(32'h14 + 4 * k) : 32'h20;
      if (k == 6) begin
        checks++;
        if (done_a !== 1'b0 || halt_a !== 1'b0) begin
          $display("FAIL t2_early_halt got done=%b halted=%b want 0/0", done_a, halt_a);
          fails++;
        end
      end
      tick();
    end
    checks++;
    if ({crst_a, run_a, done_a, halt_a, to_a} !== 5'b00110 || cnt_a !== 32'd6) begin
      $display("FAIL t2_halt got %b cnt=%0d want 00110 cnt=6", {crst_a, run_a, done_a, halt_a, to_a}, cnt_a);
      fails++;
    end
    idx_a = 4'd0;
    #1;
    checks++;
    if (tcnt_a !== (TR ? 5'd6 : 5'd0) || tpc_a !== (TR ? 32'h18 : 32'h0)) begin
      $display("FAIL t2_trace got tcnt=%0d pc=%h want %0d/%h", tcnt_a, tpc_a, TR ? 6 : 0, TR ? 32'h18 : 32'h0);
      fails++;
    end
  endtask
  task automatic test_halt_timeout;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    for (int k = 1; k <= 10; k++) begin
      pc_a = (k < 7) ? 32'(4 * k) : 32'h100;
      tick();
    end
    checks++;
    if ({crst_a, run_a, done_a, halt_a, to_a} !== 5'b00111 || cnt_a !== 32'd10) begin
      $display("FAIL t4_both got %b cnt=%0d want 00111 cnt=10", {crst_a, run_a, done_a, halt_a, to_a}, cnt_a);
      fails++;
    end
    pc_a = 32'h104;
    tick();
    checks++;
    if ({run_a, done_a} !== 2'b01 || cnt_a !== 32'd10) begin
      $display("FAIL t4_frozen got run/done=%b cnt=%0d want 01 cnt=10", {run_a, done_a}, cnt_a);
      fails++;
    end
  endtask
  task automatic test_trace_wrap;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    for (int k = 0; k < 20; k++) begin
      pc_b = 32'(4 * k);
      tick();
    end
    checks++;
    if ({crst_b, run_b, done_b, halt_b, to_b} !== 5'b00101 || cnt_b !== 32'd20) begin
      $display("FAIL t3_done got %b cnt=%0d want 00101 cnt=20", {crst_b, run_b, done_b, halt_b, to_b}, cnt_b);
      fails++;
    end
    checks++;
    if (tcnt_b !== (TR ? 5'd16 : 5'd0)) begin
      $display("FAIL t3_tcount got %0d want %0d", tcnt_b, TR ? 16 : 0);
      fails++;
    end
    idx_b = 4'd0;
    #1;
    checks++;
    if (tpc_b !== (TR ? 32'h10 : 32'h0)) begin
      $display("FAIL t3_idx0 got %h want %h", tpc_b, TR ? 32'h10 : 32'h0);
      fails++;
    end
    idx_b = 4'd7;
    #1;
    checks++;
    if (tpc_b !== (TR ? 32'h2C : 32'h0)) begin
      $display("FAIL t3_idx7 got %h want %h", tpc_b, TR ? 32'h2C : 32'h0);
      fails++;
    end
    idx_b = 4'd15;
    #1;
    checks++;
    if (tpc_b !== (TR ? 32'h4C : 32'h0)) begin
      $display("FAIL t3_idx15 got %h want %h", tpc_b, TR ? 32'h4C : 32'h0);
      fails++;
    end
  endtask
  task automatic test_abort_restart;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      pc_a = 32'(32'h40 + 4 * k);
      tick();
    end
    start_a = 1'b1;
    pc_a = 32'h4C;
    tick();
    start_a = 1'b0;
    checks++;
    if ({crst_a, run_a, done_a} !== 3'b010 || cnt_a !== 32'd4) begin
      $display("FAIL t5_start_in_run got %b cnt=%0d want 010 cnt=4", {crst_a, run_a, done_a}, cnt_a);
      fails++;
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({crst_a, run_a, done_a, halt_a, to_a} !== 5'b10000 || cnt_a !== 32'd0 || tcnt_a !== 5'd0) begin
      $display("FAIL t5_abort got %b cnt=%0d tcnt=%0d want 10000 0 0", {crst_a, run_a, done_a, halt_a, to_a}, cnt_a, tcnt_a);
      fails++;
    end
    rst = 1'b1;
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    pc_a = 32'h80;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if ({crst_a, run_a, done_a, halt_a, to_a} !== 5'b00110 || cnt_a !== 32'd4) begin
      $display("FAIL t5_short_halt got %b cnt=%0d want 00110 cnt=4", {crst_a, run_a, done_a, halt_a, to_a}, cnt_a);
      fails++;
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++;
    if ({crst_a, run_a, done_a, halt_a, to_a} !== 5'b10000 || cnt_a !== 32'd0 || tcnt_a !== 5'd0) begin
      $display("FAIL t5_restart got %b cnt=%0d tcnt=%0d want 10000 0 0", {crst_a, run_a, done_a, halt_a, to_a}, cnt_a, tcnt_a);
      fails++;
    end
    tick();
    checks++;
    if ({crst_a, run_a, done_a} !== 3'b010) begin
      $display("FAIL t5_rerun got %b want 010", {crst_a, run_a, done_a});
      fails++;
    end
  endtask
  initial begin
    test_reset();
    test_timeout();
    test_halt();
    test_halt_timeout();
    test_trace_wrap();
    test_abort_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
